reg_bank_cmd_bridge: RTL and testbench
======================================

REG_BANK_CMD_BRIDGE -- requirements
Module: reg_bank_cmd_bridge

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of request entries (power of 2, 2..16).
REQ-002 SHALL have parameter READ_LATENCY, default 1, cycles from read issue to valid data_out (1..7).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1, upstream request valid.
REQ-006 SHALL have port req_ready, output, 1, bridge can accept a request.
REQ-007 SHALL have port req_addr, input, 8, request register address.
REQ-008 SHALL have port req_wdata, input, 16, request write data.
REQ-009 SHALL have port req_rw, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have port address, output, 8, to register bank.
REQ-011 SHALL have port data_in, output, 16, to register bank.
REQ-012 SHALL have port rw, output, 1, to register bank; 1 = write.
REQ-013 SHALL have port data_out, input, 16, from register bank.
REQ-014 SHALL have port rsp_valid, output, 1, response valid.
REQ-015 SHALL have port rsp_ready, input, 1, downstream accepts response.
REQ-016 SHALL have port rsp_rdata, output, 16, response data.
REQ-017 SHALL have port rsp_addr, output, 8, address of the responding request.
REQ-018 SHALL have port fifo_count, output, 5, number of queued requests.

Function
REQ-019 SHALL buffer requests in an in-order FIFO of FIFO_DEPTH entries {addr, wdata, rw}.
REQ-020 SHALL drive req_ready = (fifo_count < FIFO_DEPTH) and push on req_valid & req_ready.
REQ-021 SHALL not bypass when full: req_ready stays 0 in a cycle where a pop occurs while full.
REQ-022 SHALL make a request pushed into an empty FIFO poppable no earlier than the next cycle.
REQ-023 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-024 IDLE: if FIFO non-empty, pop head into holding register, go to ISSUE; else stay.
REQ-025 ISSUE: drive address, data_in, rw from holding register for exactly one cycle.
REQ-026 ISSUE, write: go to IDLE (see REQ-034); rw SHALL be 1 only during this cycle.
REQ-027 ISSUE, read: rw = 0, load latency counter with READ_LATENCY, go to WAIT.
REQ-028 WAIT: hold address stable, decrement counter; on counter = 1 capture data_out into rsp_rdata, go to RESP.
REQ-029 RESP: assert rsp_valid with rsp_rdata, rsp_addr stable until rsp_ready; on rsp_valid & rsp_ready go to IDLE.
REQ-030 SHALL hold rw = 0 in every state other than ISSUE for a write; address and data_in hold last driven value.
REQ-031 SHALL keep accepting requests into the FIFO in any FSM state, including RESP backpressure.
REQ-032 fifo_count SHALL be unchanged on simultaneous push and pop.

Reset
REQ-033 On reset low: FIFO emptied, fifo_count = 0, state IDLE, req_ready = 0 while reset asserted then 1, rsp_valid = 0, rsp_rdata = 0, rsp_addr = 0, address = 0, data_in = 0, rw = 0; in-flight and queued requests are discarded with no response.

Configuration
REQ-034 With macro REG_BANK_BRIDGE_WR_ACK_EN defined, a write SHALL go ISSUE -> RESP with rsp_rdata = written data and rsp_addr = address; without it, writes produce no response and rsp_valid is asserted for reads only.

Verification
REQ-035 Write 0x10 <- 0xBEEF then read 0x10, READ_LATENCY=1 -> rw=1 for exactly one cycle with address=0x10, data_in=0xBEEF; rsp_rdata=0xBEEF, rsp_addr=0x10.
REQ-036 Push 5 requests back-to-back with rsp_ready=0, FIFO_DEPTH=4, first a read -> req_ready low after 4 queued requests plus one held in FSM; fifo_count=4; no loss after rsp_ready=1.
REQ-037 READ_LATENCY=3, read 0x22 where bank returns 0x1234 -> rsp_valid rises 4 cycles after ISSUE entry; rsp_rdata=0x1234.
REQ-038 rsp_ready held 0 for 10 cycles during RESP -> rsp_valid, rsp_rdata, rsp_addr stable all 10 cycles; no further bank access.
REQ-039 reset asserted during WAIT with 3 queued requests -> all outputs zero immediately, fifo_count=0, no response after release.
REQ-040 With REG_BANK_BRIDGE_WR_ACK_EN, write 0x05 <- 0x00A5 -> rsp_valid with rsp_rdata=0x00A5, rsp_addr=0x05; without macro, no rsp_valid.

Source files
------------

// File: rtl/reg_bank_cmd_bridge.sv
// Request-FIFO bridge that serialises upstream read/write commands onto a simple register-bank port.
// Define REG_BANK_BRIDGE_WR_ACK_EN to make writes return a response carrying the written data.
`timescale 1ns/1ps

module reg_bank_cmd_bridge #(
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  input  logic        req_rw,
  output logic [7:0]  address,
  output logic [15:0] data_in,
  output logic        rw,
  input  logic [15:0] data_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic [7:0]  rsp_addr,
  output logic [4:0]  fifo_count
);

  localparam int         PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);
  localparam logic [2:0] LAT_C   = 3'(READ_LATENCY);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [24:0]      r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [4:0]       r_count;

  logic [1:0]  r_state;
  logic [7:0]  r_address;
  logic [15:0] r_data_in;
  logic        r_hold_rw;
  logic [2:0]  r_lat_cnt;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_rdata;
  logic [7:0]  r_rsp_addr;

  logic w_push;
  logic w_pop;

  // NOTE: ready looks only at the registered count, so a pop while full cannot make room in the same cycle.
  assign req_ready = reset & (r_count < DEPTH_C);
  assign w_push    = req_valid & req_ready;
  assign w_pop     = (r_state == S_IDLE) && (r_count != 5'd0);

  // NOTE: payload storage has no reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= {req_addr, req_wdata, req_rw};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The holding register doubles as the bank-side address/data drivers, so they keep their last value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_address   <= '0;
      r_data_in   <= '0;
      r_hold_rw   <= 1'b0;
      r_lat_cnt   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_address, r_data_in, r_hold_rw} <= r_fifo_mem[r_rd_ptr];
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_hold_rw) begin
`ifdef REG_BANK_BRIDGE_WR_ACK_EN
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_data_in;
            r_rsp_addr  <= r_address;
            r_state     <= S_RESP;
`else
            r_state     <= S_IDLE;
`endif
          end else begin
            r_lat_cnt <= LAT_C;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_lat_cnt <= r_lat_cnt - 3'd1;
          if (r_lat_cnt == 3'd1) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= data_out;
            r_rsp_addr  <= r_address;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign address    = r_address;
  assign data_in    = r_data_in;
  assign rw         = (r_state == S_ISSUE) & r_hold_rw;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_addr   = r_rsp_addr;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_reg_bank_cmd_bridge.sv
// Randomised and directed bench for reg_bank_cmd_bridge against an in-order transaction scoreboard.
// Honours REG_BANK_BRIDGE_WR_ACK_EN the same way as the design.
`timescale 1ns/1ps

module tb_reg_bank_cmd_bridge;
  localparam int DEPTH = 4;
  localparam int RL    = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid, req_ready, req_rw, rw, rsp_valid, rsp_ready;
  logic [7:0]  req_addr, address, rsp_addr;
  logic [15:0] req_wdata, data_in, data_out, rsp_rdata;
  logic [4:0]  fifo_count;

  always #5 clk = ~clk;

  reg_bank_cmd_bridge #(.FIFO_DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rw(req_rw),
    .address(address), .data_in(data_in), .rw(rw), .data_out(data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_addr(rsp_addr), .fifo_count(fifo_count)
  );

  // Register bank: writes land on the clock edge, read data appears RL cycles after the address.
  logic [15:0] bank_mem [256];
  logic [7:0]  addr_pipe [RL];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) bank_mem[i] <= '0;
      for (int i = 0; i < RL; i++)  addr_pipe[i] <= '0;
    end else begin
      if (rw) bank_mem[address] <= data_in;
      addr_pipe[0] <= address;
      for (int i = 1; i < RL; i++) addr_pipe[i] <= addr_pipe[i-1];
    end
  end
  assign data_out = bank_mem[addr_pipe[RL-1]];

  // Reference model: in-order semantics, so a read returns the memory image after all earlier writes.
  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } rec_t;

  logic [15:0] model_mem [256];
  rec_t        rsp_q[$];
  rec_t        wr_q[$];

  int n_cmp = 0;
  int n_err = 0;

  logic        p_hold, p_rw;
  logic [15:0] p_rdata;
  logic [7:0]  p_raddr, p_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    rsp_q.delete();
    wr_q.delete();
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    p_hold = 1'b0;
    p_rw   = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rsp_addr"},  rsp_addr, 0);
    check({tag, "_address"},   address, 0);
    check({tag, "_data_in"},   data_in, 0);
    check({tag, "_rw"},        rw, 0);
    check({tag, "_fifo_count"}, fifo_count, 0);
  endtask

  // Observe the current cycle (inputs already applied), then advance to 1ns after the next edge.
  task automatic tick();
    rec_t r;
    if (req_valid && req_ready) begin
      r.a = req_addr;
      if (req_rw) begin
        r.d = req_wdata;
        model_mem[req_addr] = req_wdata;
        wr_q.push_back(r);
`ifdef REG_BANK_BRIDGE_WR_ACK_EN
        rsp_q.push_back(r);
`endif
      end else begin
        r.d = model_mem[req_addr];
        rsp_q.push_back(r);
      end
    end
    if (rw) begin
      check("rw_single_cycle", p_rw, 0);
      if (wr_q.size() == 0) check("unexpected_write", rw, 0);
      else begin
        r = wr_q.pop_front();
        check("wr_address", address, r.a);
        check("wr_data_in", data_in, r.d);
      end
    end
    if (p_hold) begin
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_rdata", rsp_rdata, p_rdata);
      check("hold_rsp_addr",  rsp_addr, p_raddr);
      check("hold_address",   address, p_addr);
    end
    if (rsp_valid) check("no_access_in_resp", rw, 0);
    if (rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) check("unexpected_rsp", rsp_valid, 0);
      else begin
        r = rsp_q.pop_front();
        check("rsp_addr",  rsp_addr, r.a);
        check("rsp_rdata", rsp_rdata, r.d);
      end
    end
    p_hold  = rsp_valid && !rsp_ready;
    p_rdata = rsp_rdata;
    p_raddr = rsp_addr;
    p_addr  = address;
    p_rw    = rw;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [15:0] d, input logic w);
    logic acc;
    acc       = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_rw    = w;
    for (int g = 0; g < 200; g++) begin
      acc = req_ready;
      tick();
      if (acc) break;
    end
    if (!acc) check("push_timeout", acc, 1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int g = 0; g < 2000; g++) begin
      if (rsp_q.size() == 0 && wr_q.size() == 0 && fifo_count == 0) break;
      tick();
    end
    repeat (RL + 4) tick();
    check("drain_rsp_q", rsp_q.size(), 0);
    check("drain_wr_q",  wr_q.size(), 0);
    check("drain_fifo_count", fifo_count, 0);
  endtask

  initial begin
    int lat;
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_rw = 1'b0; rsp_ready = 1'b0;
    clear_model();
    p_rdata = '0; p_raddr = '0; p_addr = '0;

    #2;
    check_zero_outputs("in_reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1 check("ready_after_reset", req_ready, 1);

    // Write then read back the same register.
    rsp_ready = 1'b1;
    push(8'h10, 16'hBEEF, 1'b1);
    push(8'h10, 16'h0000, 1'b0);
    drain();

    // Lone write: acknowledged only when write acks are enabled.
    push(8'h05, 16'h00A5, 1'b1);
`ifdef REG_BANK_BRIDGE_WR_ACK_EN
    drain();
`else
    for (int i = 0; i < RL + 6; i++) begin
      check("write_no_rsp", rsp_valid, 0);
      tick();
    end
    drain();
`endif

    // Read latency: push at cycle k, pop at k+1, ISSUE at k+2, response RL+1 cycles after ISSUE.
    push(8'h22, 16'h1234, 1'b1);
    drain();
    push(8'h22, 16'h0000, 1'b0);
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("read_latency", lat, RL + 3);
    check("read_0x22_data", rsp_rdata, 16'h1234);
    drain();

    // Backpressure: five back-to-back requests, one held in the FSM and four queued.
    rsp_ready = 1'b0;
    push(8'h10, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 7)), 16'($urandom), 1'($urandom));
    check("full_req_ready", req_ready, 0);
    check("full_fifo_count", fifo_count, DEPTH);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("bp_rsp_valid", rsp_valid, 1);
    for (int i = 0; i < 10; i++) tick();
    check("bp_fifo_count", fifo_count, DEPTH);
    check("bp_req_ready", req_ready, 0);
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      req_valid = 1'($urandom);
      req_rw    = 1'($urandom);
      req_addr  = 8'($urandom_range(0, 7));
      req_wdata = 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // Reset while a read sits in WAIT with three requests queued.
    rsp_ready = 1'b0;
    push(8'h03, 16'h0000, 1'b0);
    push(8'h04, 16'h1111, 1'b1);
    push(8'h05, 16'h0000, 1'b0);
    push(8'h06, 16'h2222, 1'b1);
    check("pre_reset_count", fifo_count, 3);
    #1 reset = 1'b0;
    #1 check_zero_outputs("async_reset");
    clear_model();
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("post_reset_no_rsp", rsp_valid, 0);
      check("post_reset_no_write", rw, 0);
      tick();
    end

    // Bridge still functional after reset.
    push(8'h3C, 16'hC0DE, 1'b1);
    push(8'h3C, 16'h0000, 1'b0);
    push(8'h03, 16'h0000, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
